// File: rtl/led_display_pkg.sv
// Shared types and parameter helpers for the HUB75 panel driver.
// Build with LED_DISPLAY_TEST_PATTERN_EN to enable the colour-bar source.
package led_display_pkg;

    typedef struct packed {
        logic b;
        logic g;
        logic r;
    } rgb_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_BLANK,
        ST_LATCH,
        ST_UNBLANK
    } state_t;

    function automatic int calc_addr_w(input int rows);
        return (rows / 2 > 1) ? $clog2(rows / 2) : 1;
    endfunction

    function automatic int calc_bclk_half(input int sys_hz, input int bclk_hz);
        int h;
        h = sys_hz / (2 * bclk_hz);
        return (h < 1) ? 1 : h;
    endfunction

endpackage

// File: rtl/led_display_bclk_gen.sv
// Counter-based panel shift clock: low phase first, then high phase.
// Flags the edges where bclk rises/falls and the end of the final period.
module led_display_bclk_gen #(
    parameter int HALF    = 2,
    parameter int PERIODS = 64
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic bclk,
    output logic rise,
    output logic fall,
    output logic last
);

    localparam int HW = (HALF > 1) ? $clog2(HALF) : 1;
    localparam int PW = $clog2(PERIODS + 1);

    logic [HW-1:0] half_cnt;
    logic [PW-1:0] per_cnt;
    logic          half_end;

    assign half_end = (half_cnt == HW'(HALF - 1));
    assign rise     = en && !bclk && half_end;
    assign fall     = en && bclk && half_end;
    assign last     = fall && (per_cnt == PW'(PERIODS - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            half_cnt <= '0;
            per_cnt  <= '0;
            bclk     <= 1'b0;
        end else if (!en) begin
            half_cnt <= '0;
            per_cnt  <= '0;
            bclk     <= 1'b0;
        end else if (half_end) begin
            half_cnt <= '0;
            bclk     <= ~bclk;
            if (bclk) begin
                per_cnt <= per_cnt + 1'b1;
            end
        end else begin
            half_cnt <= half_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/led_display_driver_phy.sv
// HUB75 row-pair serialiser: shift, blank, latch, unblank per row.
// Define LED_DISPLAY_TEST_PATTERN_EN for internal vertical colour bars.
module led_display_driver_phy
    import led_display_pkg::*;
#(
    parameter int SYS_CLK_FREQ   = 100_000_000,
    parameter int NUM_ROW_PIXELS = 32,
    parameter int NUM_COL_PIXELS = 64,
    parameter int BCLK_FREQ      = 25_000_000,
    localparam int ADDR_W        = calc_addr_w(NUM_ROW_PIXELS)
) (
    input  logic                        clk_in,
    input  logic                        n_reset_in,
    input  logic [3*NUM_COL_PIXELS-1:0] rgb_top_in,
    input  logic [3*NUM_COL_PIXELS-1:0] rgb_bot_in,
    input  logic                        row_valid_in,
    output logic                        row_ready_out,
    output logic [ADDR_W-1:0]           row_addr_out,
    output logic                        r0_out,
    output logic                        g0_out,
    output logic                        b0_out,
    output logic                        r1_out,
    output logic                        g1_out,
    output logic                        b1_out,
    output logic                        bclk_out,
    output logic                        latch_out,
    output logic                        oe_n_out,
    output logic [ADDR_W-1:0]           addr_out
);

    localparam int BCLK_HALF = calc_bclk_half(SYS_CLK_FREQ, BCLK_FREQ);
    localparam int ROW_W     = 3 * NUM_COL_PIXELS;
    localparam int PAIRS     = NUM_ROW_PIXELS / 2;
    localparam int HW        = (BCLK_HALF > 1) ? $clog2(BCLK_HALF) : 1;

    logic [ROW_W-1:0] src_top;
    logic [ROW_W-1:0] src_bot;
    logic             src_valid;

`ifdef LED_DISPLAY_TEST_PATTERN_EN
    logic unused_ext;

    always_comb begin
        src_top = '0;
        for (int c = 0; c < NUM_COL_PIXELS; c++) begin
            src_top[3*c +: 3] = 3'((c >> 3) & 7);
        end
    end

    assign src_bot    = src_top;
    assign src_valid  = 1'b1;
    assign unused_ext = ^{rgb_top_in, rgb_bot_in, row_valid_in};
`else
    assign src_top   = rgb_top_in;
    assign src_bot   = rgb_bot_in;
    assign src_valid = row_valid_in;
`endif

    state_t           state;
    state_t           state_n;
    logic [HW-1:0]    hold_cnt;
    logic             hold_end;
    logic             accept;
    logic [ROW_W-1:0] sr_top;
    logic [ROW_W-1:0] sr_bot;
    logic             shift_fall;
    logic             shift_last;
    logic             unused_rise;
    rgb_t             top_px;
    rgb_t             bot_px;

    led_display_bclk_gen #(
        .HALF    (BCLK_HALF),
        .PERIODS (NUM_COL_PIXELS)
    ) u_bclk (
        .clk   (clk_in),
        .rst_n (n_reset_in),
        .en    (state == ST_SHIFT),
        .bclk  (bclk_out),
        .rise  (unused_rise),
        .fall  (shift_fall),
        .last  (shift_last)
    );

    assign row_ready_out = (state == ST_IDLE);
    assign accept        = row_ready_out && src_valid;
    assign hold_end      = (hold_cnt == HW'(BCLK_HALF - 1));

    always_comb begin
        state_n = state;
        unique case (state)
            ST_IDLE:    if (accept) state_n = ST_SHIFT;
            ST_SHIFT:   if (shift_last) state_n = ST_BLANK;
            ST_BLANK:   if (hold_end) state_n = ST_LATCH;
            ST_LATCH:   if (hold_end) state_n = ST_UNBLANK;
            ST_UNBLANK: state_n = ST_IDLE;
            default:    state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge n_reset_in) begin
        if (!n_reset_in) begin
            state    <= ST_IDLE;
            hold_cnt <= '0;
        end else begin
            state <= state_n;
            if (state != state_n) begin
                hold_cnt <= '0;
            end else if (state == ST_BLANK || state == ST_LATCH) begin
                hold_cnt <= hold_cnt + 1'b1;
            end
        end
    end

    // Data moves on the same edge that drops bclk, so it is stable at each rise.
    always_ff @(posedge clk_in or negedge n_reset_in) begin
        if (!n_reset_in) begin
            sr_top <= '0;
            sr_bot <= '0;
        end else if (accept) begin
            sr_top <= src_top;
            sr_bot <= src_bot;
        end else if (shift_fall && !shift_last) begin
            sr_top <= sr_top << 3;
            sr_bot <= sr_bot << 3;
        end
    end

    // The displayed row stays lit while the next one shifts in.
    always_ff @(posedge clk_in or negedge n_reset_in) begin
        if (!n_reset_in) begin
            latch_out    <= 1'b0;
            oe_n_out     <= 1'b1;
            addr_out     <= '0;
            row_addr_out <= '0;
        end else begin
            latch_out <= (state_n == ST_LATCH);
            if (state_n == ST_BLANK) begin
                oe_n_out <= 1'b1;
            end else if (state_n == ST_UNBLANK) begin
                oe_n_out <= 1'b0;
            end
            if (state == ST_BLANK && state_n == ST_LATCH) begin
                addr_out <= row_addr_out;
            end
            if (state == ST_UNBLANK) begin
                if (row_addr_out == ADDR_W'(PAIRS - 1)) begin
                    row_addr_out <= '0;
                end else begin
                    row_addr_out <= row_addr_out + 1'b1;
                end
            end
        end
    end

    assign top_px = rgb_t'(sr_top[ROW_W-1 -: 3]);
    assign bot_px = rgb_t'(sr_bot[ROW_W-1 -: 3]);

    assign r0_out = top_px.r;
    assign g0_out = top_px.g;
    assign b0_out = top_px.b;
    assign r1_out = bot_px.r;
    assign g1_out = bot_px.g;
    assign b1_out = bot_px.b;

endmodule

// File: tb/tb_led_display_driver_phy.sv
// Scoreboard bench for the HUB75 driver: stimulus queues expected pixels,
// a negedge monitor checks them at every bclk rise and every latch pulse.
`timescale 1ns/1ps
module tb_led_display_driver_phy;

    localparam int COLS = 64;
    localparam int ROWW = 3 * COLS;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [ROWW-1:0] top_in = '0;
    logic [ROWW-1:0] bot_in = '0;
    logic            valid = 1'b0;
    logic            row_ready;
    logic [3:0]      row_addr;
    logic            r0, g0, b0, r1, g1, b1;
    logic            bclk, latch, oe_n;
    logic [3:0]      addr;

    always #5 clk = ~clk;

    led_display_driver_phy dut (
        .clk_in        (clk),
        .n_reset_in    (rst_n),
        .rgb_top_in    (top_in),
        .rgb_bot_in    (bot_in),
        .row_valid_in  (valid),
        .row_ready_out (row_ready),
        .row_addr_out  (row_addr),
        .r0_out        (r0),
        .g0_out        (g0),
        .b0_out        (b0),
        .r1_out        (r1),
        .g1_out        (g1),
        .b1_out        (b1),
        .bclk_out      (bclk),
        .latch_out     (latch),
        .oe_n_out      (oe_n),
        .addr_out      (addr)
    );

    logic [5:0] exp_px[$];
    logic [3:0] exp_addr[$];
    int         vectors = 0;
    int         errors = 0;
    int         latches = 0;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    // Monitor
    logic prev_bclk = 1'b0;
    logic prev_latch = 1'b0;
    int   rises = 0;
    time  last_rise = 0;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_bclk  = 1'b0;
            prev_latch = 1'b0;
            rises      = 0;
        end else begin
            if (bclk && !prev_bclk) begin
                if (rises > 0) check("bclk_period", $time - last_rise, 40);
                last_rise = $time;
                rises++;
                if (exp_px.size() == 0) begin
                    check("unexpected_bclk", 1, 0);
                end else begin
                    check("pixel", {b1, g1, r1, b0, g0, r0},
                          exp_px.pop_front());
                end
            end
            if (latch) check("bclk_in_latch", bclk, 0);
            if (latch && !prev_latch) begin
                check("rises_per_row", rises, COLS);
                check("oe_in_latch", oe_n, 1);
                rises = 0;
                if (exp_addr.size() == 0) begin
                    check("unexpected_latch", 1, 0);
                end else begin
                    check("addr_at_latch", addr, exp_addr.pop_front());
                end
                latches++;
            end
            prev_bclk  = bclk;
            prev_latch = latch;
        end
    end

    // Driver
    bit         sent = 0;
    bit         shown = 0;
    logic [3:0] prev_idx = '0;

    task automatic wait_ready();
        int n = 0;
        while (!row_ready && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (!row_ready) check("ready_timeout", 0, 1);
    endtask

    task automatic push_row(input logic [3:0] idx, input logic [ROWW-1:0] t,
                            input logic [ROWW-1:0] b);
        for (int c = COLS - 1; c >= 0; c--) begin
            exp_px.push_back({b[3*c +: 3], t[3*c +: 3]});
        end
        exp_addr.push_back(idx);
    endtask

    task automatic send_row(input logic [3:0] idx, input logic [ROWW-1:0] t,
                            input logic [ROWW-1:0] b);
        @(negedge clk);
        wait_ready();
        if (sent) begin
            shown = 1;
            check("addr_lag", addr, prev_idx);
        end
        check("row_addr", row_addr, idx);
        check("oe_idle", oe_n, !shown);
        push_row(idx, t, b);
        top_in = t;
        bot_in = b;
        valid  = 1'b1;
        @(negedge clk);
        valid  = 1'b0;
        top_in = ~t;
        bot_in = ~b;
        check("ready_drop", row_ready, 0);
        sent     = 1;
        prev_idx = idx;
    endtask

    task automatic reset_checks(input string tag);
        check({tag, "_oe_n"}, oe_n, 1);
        check({tag, "_latch"}, latch, 0);
        check({tag, "_bclk"}, bclk, 0);
        check({tag, "_addr"}, addr, 0);
        check({tag, "_ready"}, row_ready, 1);
        check({tag, "_row_addr"}, row_addr, 0);
        check({tag, "_data"}, {b1, g1, r1, b0, g0, r0}, 0);
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [ROWW-1:0] pt;
        logic [ROWW-1:0] pb;
        #100;
        reset_checks("reset");
`ifdef LED_DISPLAY_TEST_PATTERN_EN
        pt = '0;
        for (int c = 0; c < COLS; c++) pt[3*c +: 3] = 3'((c >> 3) & 7);
        for (int i = 0; i < 8; i++) push_row(4'(i), pt, pt);
        #2 rst_n = 1'b1;
        for (int n = 0; n < 4000 && latches < 8; n++) @(negedge clk);
        check("pattern_rows", latches, 8);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 reset_checks("pattern_reset");
`else
        #2 rst_n = 1'b1;
        send_row(4'd0, ROWW'(1), '0);
        for (int i = 1; i < 16; i++) begin
            pt = {6{32'hA5A5_0F0F ^ (32'(i) * 32'h0101_0101)}};
            pb = {6{32'h3C3C_F0F0 + 32'(i)}};
            send_row(4'(i), pt, pb);
        end
        send_row(4'd0, '1, '1);
        send_row(4'd1, {6{32'h1234_5678}}, '0);
        send_row(4'd2, {6{32'hFFFF_0000}}, {6{32'h0000_FFFF}});
        repeat (60) @(negedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 reset_checks("mid_reset");
        exp_px.delete();
        exp_addr.delete();
        sent  = 0;
        shown = 0;
        #40;
        @(posedge clk);
        #2 rst_n = 1'b1;
        send_row(4'd0, {6{32'hDEAD_BEEF}}, {6{32'h0BAD_F00D}});
        @(negedge clk);
        wait_ready();
        check("final_px_queue", exp_px.size(), 0);
        check("final_addr_queue", exp_addr.size(), 0);
        check("final_oe", oe_n, 0);
        check("final_addr", addr, 0);
        check("final_row_addr", row_addr, 1);
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
